// File: rtl/stabilizer_row_sink.sv
// Receiving end of the stabilizer-row stream: collects num_qubit rows into a
// literal matrix plus phase column, reports full/overflow/|0..0> status and
// offers a registered random-access read port.
module stabilizer_row_sink #(
    parameter int num_qubit = 3
) (
    input  logic                        clk,
    input  logic                        rst_new,
    input  logic [1:0]                  literals_in [0:num_qubit-1],
    input  logic                        phase_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    input  logic                        clear_in,
    input  logic                        rd_en,
    input  logic [$clog2(num_qubit)-1:0] rd_addr,
    output logic [1:0]                  rd_literals_out [0:num_qubit-1],
    output logic                        rd_phase_out,
    output logic                        rd_valid_out,
    output logic [$clog2(num_qubit+1)-1:0] row_count_out,
    output logic                        full_out,
    output logic                        overflow_out,
    output logic                        basis_zero_out
);
    localparam int AW = $clog2(num_qubit);
    localparam int CW = $clog2(num_qubit + 1);

    typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          bz_q, bz_d;
    logic          wr_en;
    logic          ident;

    logic [1:0]    mat_q   [0:num_qubit-1][0:num_qubit-1];
    logic          phase_q [0:num_qubit-1];

    logic          rd_valid_q, rd_valid_d;
    logic [1:0]    rd_lit_q [0:num_qubit-1];
    logic [1:0]    rd_lit_d [0:num_qubit-1];
    logic          rd_ph_q, rd_ph_d;

    // Status outputs come straight from registers; no path from valid_in.
    assign ready_out       = (state_q == COLLECT);
    assign full_out        = (state_q == FULL);
    assign row_count_out   = cnt_q;
    assign overflow_out    = ovf_q;
    assign basis_zero_out  = bz_q;
    assign rd_valid_out    = rd_valid_q;
    assign rd_phase_out    = rd_ph_q;
    assign rd_literals_out = rd_lit_q;

    // Stored matrix is the identity-Z pattern (Z on the diagonal, I elsewhere, phase +).
    always_comb begin
        ident = 1'b1;
        for (int r = 0; r < num_qubit; r++) begin
            if (phase_q[r]) ident = 1'b0;
            for (int c = 0; c < num_qubit; c++) begin
                if (mat_q[r][c] != ((r == c) ? 2'd1 : 2'd0)) ident = 1'b0;
            end
        end
    end

    // Next-state / control: clear wins over any same-cycle row.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        bz_d    = 1'b0;
        wr_en   = 1'b0;
        if (clear_in) begin
            state_d = COLLECT;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (valid_in) begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(num_qubit - 1)) state_d = FULL;
                    end
                end
                FULL: begin
                    if (valid_in) ovf_d = 1'b1;
                    bz_d = ident;
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst_new) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            bz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            bz_q    <= bz_d;
        end
    end

    // Matrix storage: the accepted row lands at index row_count.
    always_ff @(posedge clk) begin
        if (rst_new || clear_in) begin
            for (int r = 0; r < num_qubit; r++) begin
                phase_q[r] <= 1'b0;
                for (int c = 0; c < num_qubit; c++) mat_q[r][c] <= 2'd0;
            end
        end else if (wr_en) begin
            for (int r = 0; r < num_qubit; r++) begin
                if (CW'(r) == cnt_q) begin
                    phase_q[r] <= phase_in;
                    for (int c = 0; c < num_qubit; c++) mat_q[r][c] <= literals_in[c];
                end
            end
        end
    end

    // Read mux reads the pre-edge matrix, so same-cycle write/clear returns old data.
    always_comb begin
        rd_valid_d = 1'b0;
        rd_ph_d    = 1'b0;
        for (int c = 0; c < num_qubit; c++) rd_lit_d[c] = 2'd0;
        for (int r = 0; r < num_qubit; r++) begin
            if (rd_en && (AW'(r) == rd_addr)) begin
                rd_valid_d = 1'b1;
                rd_ph_d    = phase_q[r];
                for (int c = 0; c < num_qubit; c++) rd_lit_d[c] = mat_q[r][c];
            end
        end
    end

    // Read port registers (one cycle latency).
    always_ff @(posedge clk) begin
        if (rst_new) begin
            rd_valid_q <= 1'b0;
            rd_ph_q    <= 1'b0;
            for (int c = 0; c < num_qubit; c++) rd_lit_q[c] <= 2'd0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_ph_q    <= rd_ph_d;
            rd_lit_q   <= rd_lit_d;
        end
    end
endmodule

// File: tb/tb_stabilizer_row_sink.sv
// Directed bench for stabilizer_row_sink with num_qubit = 3.
module tb_stabilizer_row_sink;
    localparam int NQ = 3;

    logic       clk = 1'b0;
    logic       rst_new;
    logic [1:0] lit [0:NQ-1];
    logic       phase_in, valid_in, clear_in, rd_en;
    logic [1:0] rd_addr;
    logic [1:0] rd_lit [0:NQ-1];
    logic       ready_out, rd_phase_out, rd_valid_out, full_out, overflow_out, basis_zero_out;
    logic [1:0] row_count_out;

    int checks = 0;
    int failures = 0;

    stabilizer_row_sink #(.num_qubit(NQ)) dut (
        .clk(clk), .rst_new(rst_new), .literals_in(lit), .phase_in(phase_in),
        .valid_in(valid_in), .ready_out(ready_out), .clear_in(clear_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_literals_out(rd_lit),
        .rd_phase_out(rd_phase_out), .rd_valid_out(rd_valid_out),
        .row_count_out(row_count_out), .full_out(full_out),
        .overflow_out(overflow_out), .basis_zero_out(basis_zero_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_row(input logic [5:0] l, input logic ph);
        lit[0] = l[5:4]; lit[1] = l[3:2]; lit[2] = l[1:0];
        phase_in = ph;
        valid_in = 1'b1;
    endtask

    task automatic send_row(input logic [5:0] l, input logic ph);
        set_row(l, ph);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic [1:0] cnt, input logic full,
                              input logic ovf, input logic bz);
        chk({tag, ".count"}, 32'(row_count_out), 32'(cnt));
        chk({tag, ".full"},  32'(full_out), 32'(full));
        chk({tag, ".ready"}, 32'(ready_out), 32'(!full));
        chk({tag, ".ovf"},   32'(overflow_out), 32'(ovf));
        chk({tag, ".bz"},    32'(basis_zero_out), 32'(bz));
    endtask

    task automatic chk_rd(input string tag, input logic v, input logic [5:0] l, input logic ph);
        chk({tag, ".rv"},  32'(rd_valid_out), 32'(v));
        chk({tag, ".rl"},  32'({rd_lit[0], rd_lit[1], rd_lit[2]}), 32'(l));
        chk({tag, ".rph"}, 32'(rd_phase_out), 32'(ph));
    endtask

    task automatic read_row(input string tag, input logic [1:0] a, input logic v,
                            input logic [5:0] l, input logic ph);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        chk_rd(tag, v, l, ph);
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
    endtask

    initial begin
        rst_new = 1'b1; valid_in = 1'b0; clear_in = 1'b0; rd_en = 1'b0; rd_addr = 2'd0;
        phase_in = 1'b0; lit[0] = 2'd0; lit[1] = 2'd0; lit[2] = 2'd0;
        tick(); tick();
        chk_status("reset", 2'd0, 1'b0, 1'b0, 1'b0);
        chk_rd("reset", 1'b0, 6'b0, 1'b0);
        rst_new = 1'b0;

        // T1: identity rows back to back
        send_row(6'b01_00_00, 1'b0); chk("t1.c1", 32'(row_count_out), 32'd1);
        send_row(6'b00_01_00, 1'b0); chk("t1.c2", 32'(row_count_out), 32'd2);
        send_row(6'b00_00_01, 1'b0);
        chk_status("t1.full", 2'd3, 1'b1, 1'b0, 1'b0);
        tick();
        chk_status("t1.bz", 2'd3, 1'b1, 1'b0, 1'b1);

        // T4: surplus row sets sticky overflow, matrix untouched
        send_row(6'b11_11_11, 1'b1);
        chk_status("t4.ovf", 2'd3, 1'b1, 1'b1, 1'b1);
        tick();
        chk_status("t4.sticky", 2'd3, 1'b1, 1'b1, 1'b1);
        read_row("t4.r0", 2'd0, 1'b1, 6'b01_00_00, 1'b0);
        read_row("t4.r1", 2'd1, 1'b1, 6'b00_01_00, 1'b0);
        read_row("t4.r2", 2'd2, 1'b1, 6'b00_00_01, 1'b0);
        read_row("t4.r3", 2'd3, 1'b0, 6'b0, 1'b0);
        tick();
        chk_rd("t4.idle", 1'b0, 6'b0, 1'b0);

        // T5: clear + valid + read same cycle while full; read returns pre-clear row 0
        set_row(6'b10_10_10, 1'b1);
        clear_in = 1'b1; rd_en = 1'b1; rd_addr = 2'd0;
        tick();
        clear_in = 1'b0; valid_in = 1'b0; rd_en = 1'b0;
        chk_status("t5.clr", 2'd0, 1'b0, 1'b0, 1'b0);
        chk_rd("t5.preclr", 1'b1, 6'b01_00_00, 1'b0);
        read_row("t5.r0", 2'd0, 1'b1, 6'b0, 1'b0);
        read_row("t5.r1", 2'd1, 1'b1, 6'b0, 1'b0);
        read_row("t5.r2", 2'd2, 1'b1, 6'b0, 1'b0);

        // T2: refill with 2-cycle gaps; row 0 read in its write cycle returns old data
        set_row(6'b01_00_00, 1'b0); rd_en = 1'b1; rd_addr = 2'd0;
        tick();
        valid_in = 1'b0; rd_en = 1'b0;
        chk_rd("t2.rbw", 1'b1, 6'b0, 1'b0);
        chk("t2.c1", 32'(row_count_out), 32'd1);
        tick(); tick();
        chk("t2.gap1", 32'(row_count_out), 32'd1);
        send_row(6'b00_01_00, 1'b0); chk("t2.c2", 32'(row_count_out), 32'd2);
        tick(); tick();
        chk_status("t2.gap2", 2'd2, 1'b0, 1'b0, 1'b0);
        send_row(6'b00_00_01, 1'b0);
        chk_status("t2.full", 2'd3, 1'b1, 1'b0, 1'b0);
        tick();
        chk_status("t2.bz", 2'd3, 1'b1, 1'b0, 1'b1);
        read_row("t2.r0", 2'd0, 1'b1, 6'b01_00_00, 1'b0);

        // T3a: row 1 phase set -> not basis zero
        do_clear();
        send_row(6'b01_00_00, 1'b0);
        send_row(6'b00_01_00, 1'b1);
        send_row(6'b00_00_01, 1'b0);
        tick();
        chk_status("t3a", 2'd3, 1'b1, 1'b0, 1'b0);
        read_row("t3a.r1", 2'd1, 1'b1, 6'b00_01_00, 1'b1);

        // T3b: row 2 carries an X on column 0 -> not basis zero
        do_clear();
        send_row(6'b01_00_00, 1'b0);
        send_row(6'b00_01_00, 1'b0);
        send_row(6'b10_00_01, 1'b0);
        tick();
        chk_status("t3b", 2'd3, 1'b1, 1'b0, 1'b0);

        // T6: reset after two rows; read during reset ignored
        do_clear();
        send_row(6'b01_00_00, 1'b0);
        send_row(6'b00_01_00, 1'b0);
        chk("t6.pre", 32'(row_count_out), 32'd2);
        rst_new = 1'b1; rd_en = 1'b1; rd_addr = 2'd0;
        tick();
        rst_new = 1'b0; rd_en = 1'b0;
        chk_status("t6.rst", 2'd0, 1'b0, 1'b0, 1'b0);
        chk_rd("t6.rdrst", 1'b0, 6'b0, 1'b0);
        read_row("t6.r0", 2'd0, 1'b1, 6'b0, 1'b0);
        read_row("t6.r1", 2'd1, 1'b1, 6'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
